// File: rtl/inport_buffer.sv
// Ingress buffer: sign-extends external integer samples into the internal fixed-point
// format and queues them in a show-ahead FIFO. Optional drop counter via INPORT_DROP_CNT_EN.
module inport_buffer #(
    parameter int EXT_MSB          = 23,
    parameter int MSB              = 31,
    parameter int NUM_BITS_DECIMAL = 8,
    parameter int DEPTH            = 4,
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [EXT_MSB:0]   in_data,
    input  logic               in_data_en,
    output logic [MSB:0]       internal_data,
    output logic               internal_data_en,
    input  logic               internal_ready,
    output logic [AW:0]        fill_level,
    output logic               overflow,
    input  logic               clr_overflow
`ifdef INPORT_DROP_CNT_EN
    ,
    output logic [15:0]        drop_count
`endif
);

    localparam int         INT_W      = MSB + 1 - NUM_BITS_DECIMAL;
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    generate
        if (MSB < EXT_MSB + NUM_BITS_DECIMAL) begin : g_width_check
            $error("inport_buffer: MSB too small for EXT_MSB + NUM_BITS_DECIMAL");
        end
        if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
            $error("inport_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Integer part is sign-extended, fraction bits are zero.
    logic signed [INT_W-1:0] int_ext;
    logic [MSB:0]            conv;

    assign int_ext = INT_W'($signed(in_data));

    generate
        if (NUM_BITS_DECIMAL > 0) begin : g_frac
            assign conv = {int_ext, {NUM_BITS_DECIMAL{1'b0}}};
        end else begin : g_no_frac
            assign conv = int_ext;
        end
    endgenerate

    logic [MSB:0]  stg_data_reg;
    logic          stg_vld_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   fill_reg;
    logic          overflow_reg;
    logic [MSB:0]  mem [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic wr_en;
    logic drop;

    assign empty = (fill_reg == '0);
    assign full  = (fill_reg == FULL_LEVEL);
    assign pop   = !empty && internal_ready;
    // When full, a push only lands if the head leaves in the same cycle.
    assign wr_en = stg_vld_reg && (!full || pop);
    assign drop  = stg_vld_reg && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_data_reg <= '0;
            stg_vld_reg  <= 1'b0;
        end else begin
            stg_vld_reg <= in_data_en;
            if (in_data_en) begin
                stg_data_reg <= conv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= stg_data_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !pop) begin
                fill_reg <= fill_reg + (AW + 1)'(1);
            end else if (pop && !wr_en) begin
                fill_reg <= fill_reg - (AW + 1)'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clr_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

`ifdef INPORT_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (drop) begin
            if (clr_overflow) begin
                drop_cnt_reg <= 16'd1;
            end else if (drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end else if (clr_overflow) begin
            drop_cnt_reg <= '0;
        end
    end

    assign drop_count = drop_cnt_reg;
`endif

    assign internal_data    = empty ? '0 : mem[rd_ptr_reg];
    assign internal_data_en = !empty;
    assign fill_level       = fill_reg;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_inport_buffer.sv
// Directed plus randomized bench for inport_buffer against a queue-based reference model.
module tb_inport_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_data_en = 1'b0;
    logic        internal_ready = 1'b0;
    logic        clr_overflow = 1'b0;
    logic [31:0] internal_data;
    logic        internal_data_en;
    logic [2:0]  fill_level;
    logic        overflow;
`ifdef INPORT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    inport_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_data_en       (in_data_en),
        .internal_data    (internal_data),
        .internal_data_en (internal_data_en),
        .internal_ready   (internal_ready),
        .fill_level       (fill_level),
        .overflow         (overflow),
        .clr_overflow     (clr_overflow)
`ifdef INPORT_DROP_CNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected FIFO contents, pending staged sample, sticky flag, counter.
    int exp_q[$];
    bit stg_v = 1'b0;
    int stg_w = 0;
    bit exp_ovf = 1'b0;
    int exp_cnt = 0;

    function automatic int conv(logic [23:0] d);
        return int'($signed(d)) * 256;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".en"},   32'(internal_data_en), 32'(exp_q.size() != 0));
        chk({tag, ".data"}, internal_data, (exp_q.size() != 0) ? exp_q[0] : 0);
        chk({tag, ".fill"}, 32'(fill_level), exp_q.size());
        chk({tag, ".ovf"},  32'(overflow), 32'(exp_ovf));
`ifdef INPORT_DROP_CNT_EN
        chk({tag, ".cnt"},  32'(drop_count), exp_cnt);
`endif
    endtask

    task automatic step(bit en, logic [23:0] d, bit rdy, bit clr, string tag);
        bit pop;
        bit drop;
        int tmp;
        @(negedge clk);
        in_data_en     = en;
        in_data        = d;
        internal_ready = rdy;
        clr_overflow   = clr;
        @(posedge clk);
        pop  = (exp_q.size() > 0) && rdy;
        drop = stg_v && (exp_q.size() == DEPTH) && !pop;
        if (pop) tmp = exp_q.pop_front();
        if (stg_v && !drop) exp_q.push_back(stg_w);
        if (drop) begin
            exp_ovf = 1'b1;
            exp_cnt = clr ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
        end else if (clr) begin
            exp_ovf = 1'b0;
            exp_cnt = 0;
        end
        stg_v = en;
        stg_w = conv(d);
        #1;
        chk_all(tag);
    endtask

    initial begin
        #12;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;
        step(0, 24'h0, 0, 0, "idle");

        // Conversion of extreme values, two edges of latency
        step(1, 24'hFFFFFE, 0, 0, "conv_neg_s1");
        step(0, 24'h0, 0, 0, "conv_neg_s2");
        chk("conv_neg_const", internal_data, 32'hFFFFFE00);
        step(0, 24'h0, 1, 0, "conv_neg_pop");
        step(1, 24'h7FFFFF, 0, 0, "conv_pos_s1");
        step(0, 24'h0, 0, 0, "conv_pos_s2");
        chk("conv_pos_const", internal_data, 32'h7FFFFF00);
        step(0, 24'h0, 1, 0, "conv_pos_pop");

        // Ordering
        for (int i = 1; i <= 4; i++) step(1, 24'(i), 0, 0, "order_fill");
        step(0, 24'h0, 0, 0, "order_full");
        chk("order_fill4", 32'(fill_level), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("order_head", internal_data, 32'(k * 256));
            step(0, 24'h0, 1, 0, "order_drain");
        end
        chk("order_empty", 32'(fill_level), 32'd0);

        // Overflow and clear
        for (int i = 1; i <= 4; i++) step(1, 24'(i + 16), 0, 0, "ovf_fill");
        step(1, 24'd99, 0, 0, "ovf_push5");
        step(0, 24'h0, 0, 0, "ovf_drop");
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_fill4", 32'(fill_level), 32'd4);
        chk("ovf_head", internal_data, 32'h1100);
`ifdef INPORT_DROP_CNT_EN
        chk("ovf_cnt1", 32'(drop_count), 32'd1);
`endif
        step(0, 24'h0, 0, 1, "ovf_clr");
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        step(1, 24'($urandom), 0, 0, "fullsim_prime");
        for (int i = 0; i < 10; i++) step(1, 24'($urandom), 1, 0, "fullsim");
        step(0, 24'h0, 1, 0, "fullsim_last");
        chk("fullsim_fill4", 32'(fill_level), 32'd4);
        chk("fullsim_noovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 24'h0, 1, 0, "fullsim_drain");

        // Random backpressure, input every other cycle
        for (int i = 0; i < 300; i++)
            step((i % 2) == 0, 24'($urandom), $urandom_range(0, 3) != 0, 0, "rand");
        for (int i = 0; i < 6; i++) step(0, 24'h0, 1, 0, "rand_drain");

        // Asynchronous reset with 3 entries buffered and one in flight
        for (int i = 1; i <= 3; i++) step(1, 24'(i + 32), 0, 0, "rst_fill");
        step(1, 24'd77, 0, 0, "rst_inflight");
        chk("rst_pre_fill", 32'(fill_level), 32'd3);
        @(negedge clk);
        in_data_en = 1'b0;
        internal_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_en", 32'(internal_data_en), 32'd0);
        chk("rst_async_data", internal_data, 32'd0);
        chk("rst_async_fill", 32'(fill_level), 32'd0);
        chk("rst_async_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        stg_v = 1'b0;
        exp_ovf = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 24'h0, 1, 0, "rst_post_idle");
        step(1, 24'h000123, 0, 0, "rst_post_push");
        step(0, 24'h0, 0, 0, "rst_post_vis");
        chk("rst_post_head", internal_data, 32'h00012300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
